// File: rtl/scroll_sequencer.sv
// Scroll sequencer: turns debounced direction buttons into a timed burst of
// scroll_step strobes that slide the tile array one tile in the chosen
// direction. One request can be queued in a pending latch while a move runs.
module scroll_sequencer #(
  parameter int TICK_DIV = 4,   // clocks per scroll step (2..255)
  parameter int STEPS    = 16   // scroll steps per tile move (1..63)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btnU,
  input  logic        btnD,
  input  logic        btnL,
  input  logic        btnR,
  input  logic        upEnable,
  input  logic        downEnable,
  input  logic        leftEnable,
  input  logic        rightEnable,
  output logic [1:0]  scroll_dir,
  output logic        scroll_step,
  output logic        busy,
  output logic        move_done,
  output logic        reject,
  output logic [15:0] move_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    SCROLL = 2'd2,
    DONE   = 2'd3
  } stateT;

  localparam logic [7:0] TICK_RELOAD = 8'(TICK_DIV - 1);
  localparam logic [5:0] STEP_LAST   = 6'(STEPS);

  stateT       stateReg,       stateNext;
  logic [1:0]  dirReg,         dirNext;
  logic [7:0]  tickReg,        tickNext;
  logic [5:0]  stepReg,        stepNext;
  logic        pendValidReg,   pendValidNext;
  logic [1:0]  pendDirReg,     pendDirNext;
  logic        strobeReg,      strobeNext;
  logic [15:0] moveCountReg,   moveCountNext;

  // Button priority encoder: up > down > left > right; lower ones are dropped.
  logic       btnAny;
  logic [1:0] btnDir;
  always_comb begin
    btnAny = btnU | btnD | btnL | btnR;
    if (btnU)      btnDir = 2'b00;
    else if (btnD) btnDir = 2'b01;
    else if (btnL) btnDir = 2'b10;
    else           btnDir = 2'b11;
  end

  // Select the one enable that matters for the latched direction.
  logic enSel;
  always_comb begin
    case (dirReg)
      2'b00:   enSel = upEnable;
      2'b01:   enSel = downEnable;
      2'b10:   enSel = leftEnable;
      default: enSel = rightEnable;
    endcase
  end

  // Next-state logic: request selection, enable check, step timing, pending latch.
  always_comb begin
    stateNext     = stateReg;
    dirNext       = dirReg;
    tickNext      = tickReg;
    stepNext      = stepReg;
    pendValidNext = pendValidReg;
    pendDirNext   = pendDirReg;
    strobeNext    = 1'b0;
    moveCountNext = moveCountReg;

    case (stateReg)
      IDLE: begin
        // A queued request beats any button arriving in the same cycle.
        if (pendValidReg) begin
          dirNext       = pendDirReg;
          pendValidNext = 1'b0;
          stateNext     = CHECK;
        end else if (btnAny) begin
          dirNext   = btnDir;
          stateNext = CHECK;
        end
      end
      CHECK: begin
        if (enSel) begin
          stateNext = SCROLL;
          tickNext  = TICK_RELOAD;
          stepNext  = 6'd0;
        end else begin
          stateNext = IDLE;
        end
      end
      SCROLL: begin
        if (tickReg == 8'd0) begin
          // This cycle carries a strobe; the move ends after the last one.
          tickNext = TICK_RELOAD;
          stepNext = stepReg + 6'd1;
          if (stepReg + 6'd1 == STEP_LAST) begin
            stateNext     = DONE;
            moveCountNext = moveCountReg + 16'd1;
          end
        end else begin
          tickNext = tickReg - 8'd1;
          // Register the strobe so it lines up with the cycle the counter hits 0.
          if (tickReg == 8'd1) strobeNext = 1'b1;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    // While a move is in flight the first button request is queued; later ones are lost.
    if (stateReg != IDLE && !pendValidReg && btnAny) begin
      pendValidNext = 1'b1;
      pendDirNext   = btnDir;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg     <= IDLE;
      dirReg       <= 2'b00;
      tickReg      <= 8'd0;
      stepReg      <= 6'd0;
      pendValidReg <= 1'b0;
      pendDirReg   <= 2'b00;
      strobeReg    <= 1'b0;
      moveCountReg <= 16'd0;
    end else begin
      stateReg     <= stateNext;
      dirReg       <= dirNext;
      tickReg      <= tickNext;
      stepReg      <= stepNext;
      pendValidReg <= pendValidNext;
      pendDirReg   <= pendDirNext;
      strobeReg    <= strobeNext;
      moveCountReg <= moveCountNext;
    end
  end

  // Outputs are decoded straight from registers; reject is qualified by the
  // enable sampled in the CHECK cycle so the refusal shows in that same cycle.
  always_comb begin
    scroll_dir  = dirReg;
    scroll_step = strobeReg;
    busy        = (stateReg != IDLE);
    move_done   = (stateReg == DONE);
    reject      = (stateReg == CHECK) && !enSel;
    move_count  = moveCountReg;
  end

endmodule
